// File: rtl/me_mem_loader.sv
// Stream loader for the motion-estimation accelerator: writes 256 current-block bytes
// and 1024 search-window bytes into the accelerator memories, starts it and waits for finish.
module me_mem_loader #(
  parameter int DATA_W       = 8,
  parameter int CURR_DEPTH   = 256,
  parameter int SEARCH_DEPTH = 1024,
  parameter int CURR_AW      = 8,
  parameter int SEARCH_AW    = 10,
  parameter int TIMEOUT      = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [DATA_W-1:0]    s_data_i,
  input  logic                 s_last_i,
  output logic                 curr_mem_we_o,
  output logic [CURR_AW-1:0]   curr_mem_waddr_o,
  output logic [DATA_W-1:0]    curr_mem_wdata_o,
  output logic                 search_mem_we_o,
  output logic [SEARCH_AW-1:0] search_mem_waddr_o,
  output logic [DATA_W-1:0]    search_mem_wdata_o,
  output logic                 start_o,
  input  logic                 finish_i,
  input  logic                 busy_i,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 loader_busy_o
);

  // Stream handshake: a byte transfers on a rising edge where s_valid_i and s_ready_o
  // are both high; s_ready_o is registered and only high in the two load states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CURR,
    S_LOAD_SEARCH,
    S_START,
    S_WAIT
  } state_e;

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [CURR_AW-1:0]   CURR_LAST   = CURR_AW'(CURR_DEPTH - 1);
  localparam logic [SEARCH_AW-1:0] SEARCH_LAST = SEARCH_AW'(SEARCH_DEPTH - 1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST   = WAIT_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [CURR_AW-1:0]   curr_cnt_q, curr_cnt_d;
  logic [SEARCH_AW-1:0] search_cnt_q, search_cnt_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 s_ready_q, s_ready_d;
  logic                 curr_we_q, curr_we_d;
  logic [CURR_AW-1:0]   curr_waddr_q, curr_waddr_d;
  logic [DATA_W-1:0]    curr_wdata_q, curr_wdata_d;
  logic                 search_we_q, search_we_d;
  logic [SEARCH_AW-1:0] search_waddr_q, search_waddr_d;
  logic [DATA_W-1:0]    search_wdata_q, search_wdata_d;
  logic                 start_q, start_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 beat_acc;

  assign beat_acc = s_valid_i && s_ready_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      curr_cnt_q     <= '0;
      search_cnt_q   <= '0;
      wait_cnt_q     <= '0;
      s_ready_q      <= 1'b0;
      curr_we_q      <= 1'b0;
      curr_waddr_q   <= '0;
      curr_wdata_q   <= '0;
      search_we_q    <= 1'b0;
      search_waddr_q <= '0;
      search_wdata_q <= '0;
      start_q        <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      curr_cnt_q     <= curr_cnt_d;
      search_cnt_q   <= search_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      s_ready_q      <= s_ready_d;
      curr_we_q      <= curr_we_d;
      curr_waddr_q   <= curr_waddr_d;
      curr_wdata_q   <= curr_wdata_d;
      search_we_q    <= search_we_d;
      search_waddr_q <= search_waddr_d;
      search_wdata_q <= search_wdata_d;
      start_q        <= start_d;
      done_q         <= done_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    curr_cnt_d     = curr_cnt_q;
    search_cnt_d   = search_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    s_ready_d      = s_ready_q;
    curr_we_d      = 1'b0;
    curr_waddr_d   = curr_waddr_q;
    curr_wdata_d   = curr_wdata_q;
    search_we_d    = 1'b0;
    search_waddr_d = search_waddr_q;
    search_wdata_d = search_wdata_q;
    start_d        = 1'b0;
    done_d         = 1'b0;
    err_d          = err_q;

    case (state_q)
      S_IDLE: begin
        s_ready_d = 1'b0;
        if (load_i && !busy_i) begin
          err_d        = 1'b0;
          curr_cnt_d   = '0;
          search_cnt_d = '0;
          s_ready_d    = 1'b1;
          state_d      = S_LOAD_CURR;
        end
      end
      S_LOAD_CURR: begin
        if (beat_acc) begin
          // A frame marker inside the current block is a framing error; the byte is dropped.
          if (s_last_i) begin
            err_d     = 1'b1;
            s_ready_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            curr_we_d    = 1'b1;
            curr_waddr_d = curr_cnt_q;
            curr_wdata_d = s_data_i;
            if (curr_cnt_q == CURR_LAST) begin
              state_d = S_LOAD_SEARCH;
            end else begin
              curr_cnt_d = curr_cnt_q + CURR_AW'(1);
            end
          end
        end
      end
      S_LOAD_SEARCH: begin
        if (beat_acc) begin
          if (s_last_i != (search_cnt_q == SEARCH_LAST)) begin
            err_d     = 1'b1;
            s_ready_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            search_we_d    = 1'b1;
            search_waddr_d = search_cnt_q;
            search_wdata_d = s_data_i;
            if (s_last_i) begin
              s_ready_d = 1'b0;
              state_d   = S_START;
            end else begin
              search_cnt_d = search_cnt_q + SEARCH_AW'(1);
            end
          end
        end
      end
      S_START: begin
        start_d    = 1'b1;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (finish_i) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign s_ready_o          = s_ready_q;
  assign curr_mem_we_o      = curr_we_q;
  assign curr_mem_waddr_o   = curr_waddr_q;
  assign curr_mem_wdata_o   = curr_wdata_q;
  assign search_mem_we_o    = search_we_q;
  assign search_mem_waddr_o = search_waddr_q;
  assign search_mem_wdata_o = search_wdata_q;
  assign start_o            = start_q;
  assign done_o             = done_q;
  assign err_o              = err_q;
  assign loader_busy_o      = busy_q;

endmodule

// File: tb/tb_me_mem_loader.sv
// Bench for me_mem_loader: directed sequence with randomized data, valid gaps and delays,
// expected memory writes derived from the frame layout and held in a queue.
module tb_me_mem_loader;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       load_i;
  logic       s_valid_i;
  logic       s_ready_o;
  logic [7:0] s_data_i;
  logic       s_last_i;
  logic       curr_mem_we_o;
  logic [7:0] curr_mem_waddr_o;
  logic [7:0] curr_mem_wdata_o;
  logic       search_mem_we_o;
  logic [9:0] search_mem_waddr_o;
  logic [7:0] search_mem_wdata_o;
  logic       start_o;
  logic       finish_i;
  logic       busy_i;
  logic       done_o;
  logic       err_o;
  logic       loader_busy_o;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int n_done = 0;
  // {is_search, addr[9:0], data[7:0]}
  logic [18:0] exp_q[$];

  me_mem_loader dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .load_i             (load_i),
    .s_valid_i          (s_valid_i),
    .s_ready_o          (s_ready_o),
    .s_data_i           (s_data_i),
    .s_last_i           (s_last_i),
    .curr_mem_we_o      (curr_mem_we_o),
    .curr_mem_waddr_o   (curr_mem_waddr_o),
    .curr_mem_wdata_o   (curr_mem_wdata_o),
    .search_mem_we_o    (search_mem_we_o),
    .search_mem_waddr_o (search_mem_waddr_o),
    .search_mem_wdata_o (search_mem_wdata_o),
    .start_o            (start_o),
    .finish_i           (finish_i),
    .busy_i             (busy_i),
    .done_o             (done_o),
    .err_o              (err_o),
    .loader_busy_o      (loader_busy_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every accepted good beat must be written exactly one cycle later
  always @(negedge clk) begin : mon
    logic [18:0] e;
    logic [18:0] obs;
    if (start_o === 1'b1) n_start++;
    if (done_o === 1'b1) n_done++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("write_enables", {30'd0, curr_mem_we_o, search_mem_we_o}, e[18] ? 32'd1 : 32'd2);
      obs = search_mem_we_o ? {1'b1, search_mem_waddr_o, search_mem_wdata_o}
                            : {1'b0, 2'b00, curr_mem_waddr_o, curr_mem_wdata_o};
      check("write_addr_data", {13'd0, obs}, {13'd0, e});
    end else begin
      check("no_spurious_write", {30'd0, curr_mem_we_o, search_mem_we_o}, 32'd0);
    end
  end

  // driver tasks
  task automatic do_load();
    @(negedge clk);
    load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    check("load_ready", s_ready_o, 1);
    check("load_busy", loader_busy_o, 1);
    check("load_clears_err", err_o, 0);
  endtask

  task automatic send_frame(input int n_beats, input int last_idx, input bit gaps,
                            input logic [7:0] seed);
    int   g = 0;
    int   budget = 20 * n_beats + 50;
    logic acc;
    bit   bad;
    while (g < n_beats && budget > 0) begin
      @(negedge clk);
      s_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_i  = 8'(g) ^ seed;
      s_last_i  = (g == last_idx);
      acc = s_valid_i && s_ready_o;
      @(posedge clk);
      if (acc) begin
        // frame layout: beats 0..255 current block, 256..1279 search window, last only on 1279
        bad = ((g == last_idx) != (g == 1279));
        if (!bad) begin
          if (g < 256) exp_q.push_back({1'b0, 2'b00, 8'(g), 8'(g) ^ seed});
          else         exp_q.push_back({1'b1, 10'(g - 256), 8'(g) ^ seed});
        end
        g++;
      end
      budget--;
    end
    check("frame_beats_accepted", g, n_beats);
    @(negedge clk);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic check_start_after_frame();
    check("ready_drops_after_last", s_ready_o, 0);
    check("no_start_yet", start_o, 0);
    @(negedge clk);
    check("start_pulse", start_o, 1);
  endtask

  task automatic finish_run(input int delay);
    repeat (delay) @(negedge clk);
    finish_i = 1'b1;
    @(negedge clk);
    finish_i = 1'b0;
    check("start_one_cycle", start_o, 0);
    check("done_pulse", done_o, 1);
    check("idle_after_done", loader_busy_o, 0);
    @(negedge clk);
    check("done_one_cycle", done_o, 0);
    check("no_err_after_run", err_o, 0);
  endtask

  task automatic full_run(input bit gaps, input int delay, input logic [7:0] seed);
    do_load();
    send_frame(1280, 1279, gaps, seed);
    check_start_after_frame();
    finish_run(delay);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, {25'd0, s_ready_o, curr_mem_we_o, search_mem_we_o, start_o, done_o,
                          err_o, loader_busy_o}, 0);
    check({tag, "_curr"}, {curr_mem_waddr_o, curr_mem_wdata_o}, 0);
    check({tag, "_search"}, {search_mem_waddr_o, search_mem_wdata_o}, 0);
  endtask

  // main sequence
  initial begin : main
    int s0;
    int d0;
    int k;
    rst_i = 1'b1; load_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0;
    finish_i = 1'b0; busy_i = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_i = 1'b0;

    // back-to-back frame, data = index, finish after 300 cycles
    full_run(1'b0, 300, 8'h00);

    // finish outside WAIT is ignored
    @(negedge clk);
    finish_i = 1'b1;
    @(negedge clk);
    finish_i = 1'b0;
    check("finish_in_idle_ignored", done_o, 0);

    // random valid gaps, random data and finish delay
    full_run(1'b1, $urandom_range(1, 40), 8'($urandom));
    full_run(1'b1, $urandom_range(1, 40), 8'($urandom));

    // early last on beat 100
    do_load();
    send_frame(101, 100, 1'b0, 8'($urandom));
    check("early_last_err", err_o, 1);
    check("early_last_ready", s_ready_o, 0);
    check("early_last_idle", loader_busy_o, 0);
    @(posedge clk);
    s0 = n_start;
    repeat (5) @(negedge clk);
    @(posedge clk);
    check("early_last_no_start", n_start, s0);
    full_run(1'b0, $urandom_range(1, 20), 8'($urandom));

    // missing last on beat 1279
    do_load();
    @(posedge clk);
    s0 = n_start;
    send_frame(1280, -1, 1'b0, 8'($urandom));
    check("missing_last_err", err_o, 1);
    check("missing_last_idle", loader_busy_o, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    check("missing_last_no_start", n_start, s0);

    // WAIT timeout
    do_load();
    send_frame(1280, 1279, 1'b0, 8'($urandom));
    check_start_after_frame();
    @(posedge clk);
    d0 = n_done;
    @(negedge clk);
    k = 1;
    while (err_o !== 1'b1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", k, 4096);
    check("timeout_idle", loader_busy_o, 0);
    check("timeout_no_done_now", done_o, 0);
    @(posedge clk);
    check("timeout_no_done", n_done, d0);

    // load held off while accelerator busy; finish on the WAIT entry cycle
    @(negedge clk);
    busy_i = 1'b1;
    load_i = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("busy_holdoff_ready", s_ready_o, 0);
      check("busy_holdoff_idle", loader_busy_o, 0);
      check("busy_err_sticky", err_o, 1);
    end
    busy_i = 1'b0;
    @(negedge clk);
    load_i = 1'b0;
    check("busy_release_ready", s_ready_o, 1);
    check("busy_release_err_clear", err_o, 0);
    send_frame(1280, 1279, 1'b0, 8'($urandom));
    check_start_after_frame();
    finish_run(0);

    // reset in the middle of the search window
    do_load();
    send_frame(600, -1, 1'b1, 8'($urandom));
    rst_i = 1'b1;
    @(negedge clk);
    check_outputs_zero("midload_reset");
    rst_i = 1'b0;
    full_run(1'b1, $urandom_range(1, 40), 8'($urandom));

    repeat (3) @(negedge clk);
    check("writes_outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
